// File: rtl/hwpe_ctrl_package.sv
// Shared types for the HWPE control slice: context and engine state
// encodings plus the scheduler bundles used for regfile/slave hookup.
package hwpe_ctrl_package;

    localparam int unsigned REGFILE_N_CONTEXT   = 2;
    localparam int unsigned REGFILE_N_MAX_CORES = 16;
    localparam int unsigned REGFILE_N_EVT       = 2;
    localparam int unsigned CTX_ID_WIDTH        = 8;

    localparam int unsigned CTX_IDX_W  = $clog2(REGFILE_N_CONTEXT);
    localparam int unsigned CORE_IDX_W = $clog2(REGFILE_N_MAX_CORES);
    localparam int unsigned NB_FREE_W  = $clog2(REGFILE_N_CONTEXT + 1);

    typedef enum logic [1:0] {
        CTX_FREE,
        CTX_ACQUIRED,
        CTX_READY
    } ctx_state_e;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_START,
        SCHED_RUN,
        SCHED_END
    } sched_state_e;

    typedef struct packed {
        logic                  acquire;
        logic                  trigger;
        logic [CORE_IDX_W-1:0] trigger_src;
    } ctrl_sched_t;

    typedef struct packed {
        logic [CTX_IDX_W-1:0]    ptr;
        logic [CTX_IDX_W-1:0]    running;
        logic                    busy;
        logic [NB_FREE_W-1:0]    nb_free;
        logic [CTX_ID_WIDTH-1:0] job_id;
    } flags_sched_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_sched.sv
// Job/context scheduler: tracks N_CONTEXT job contexts through
// FREE -> ACQUIRED -> READY, sequences engine start/done and routes
// the job-done event back to the core that triggered the job.
// Ports:
//   clk_i, rst_i (async, high), clear_i (sync, same as reset)
//   acquire_i / acquire_ok_o / job_id_o      : context acquisition
//   trigger_i / trigger_src_i                : commit of acquired context
//   pointer_context_o / running_context_o    : regfile context indices
//   running_job_id_o                         : ID of running job
//   start_o / done_i / busy_o                : engine handshake
//   nb_free_o                                : count of FREE contexts
//   evt_o                                    : per-core event pulses
//   err_o                                    : protocol-violation pulse
module hwpe_ctrl_ctx_sched
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int unsigned N_CORES   = REGFILE_N_MAX_CORES,
    parameter int unsigned N_EVT     = REGFILE_N_EVT,
    parameter int unsigned ID_WIDTH  = CTX_ID_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           acquire_i,
    output logic                           acquire_ok_o,
    output logic [ID_WIDTH-1:0]            job_id_o,
    input  logic                           trigger_i,
    input  logic [$clog2(N_CORES)-1:0]     trigger_src_i,
    output logic [$clog2(N_CONTEXT)-1:0]   pointer_context_o,
    output logic [$clog2(N_CONTEXT)-1:0]   running_context_o,
    output logic [ID_WIDTH-1:0]            running_job_id_o,
    output logic                           start_o,
    input  logic                           done_i,
    output logic                           busy_o,
    output logic [$clog2(N_CONTEXT+1)-1:0] nb_free_o,
    output logic [N_CORES*N_EVT-1:0]       evt_o,
    output logic                           err_o
);

    localparam int unsigned CW = $clog2(N_CONTEXT);
    localparam int unsigned SW = $clog2(N_CORES);
    localparam int unsigned FW = $clog2(N_CONTEXT + 1);

    ctx_state_e           r_ctx_st  [N_CONTEXT];
    logic [ID_WIDTH-1:0]  r_ctx_id  [N_CONTEXT];
    logic [SW-1:0]        r_ctx_src [N_CONTEXT];

    logic [CW-1:0]        r_ptr;
    logic [CW-1:0]        r_run;
    logic [ID_WIDTH-1:0]  r_job_id;
    logic [FW-1:0]        r_nb_free;
    logic                 r_err;

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;

    ctx_state_e           w_ptr_st;
    ctx_state_e           w_run_st;
    logic                 w_acq_ok;
    logic                 w_acq_fire;
    logic                 w_acq_err;
    logic                 w_trg_fire;
    logic                 w_trg_err;
    logic                 w_done_err;
    logic                 w_end;
    logic [N_CORES*N_EVT-1:0] w_evt;

    // All decisions use registered context state, so a context freed
    // by END only becomes acquirable in the following cycle.
    assign w_ptr_st   = r_ctx_st[r_ptr];
    assign w_run_st   = r_ctx_st[r_run];
    assign w_acq_ok   = (w_ptr_st == CTX_FREE);
    assign w_acq_fire = acquire_i && w_acq_ok;
    assign w_acq_err  = acquire_i && (w_ptr_st == CTX_ACQUIRED);
    assign w_trg_fire = trigger_i && (w_ptr_st == CTX_ACQUIRED);
    assign w_trg_err  = trigger_i && !w_trg_fire;
    assign w_done_err = done_i && (r_state != SCHED_RUN);
    assign w_end      = (r_state == SCHED_END);

    // Engine sequencing
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SCHED_IDLE:  if (w_run_st == CTX_READY) w_state_nxt = SCHED_START;
            SCHED_START: w_state_nxt = SCHED_RUN;
            SCHED_RUN:   if (done_i) w_state_nxt = SCHED_END;
            SCHED_END:   w_state_nxt = SCHED_IDLE;
            default:     w_state_nxt = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SCHED_IDLE;
        end else if (clear_i) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-context state. Acquire and trigger both target the pointer
    // context but need FREE vs ACQUIRED, so they never collide; END
    // targets the running context, which is READY and thus untouched
    // by acquire/trigger even when pointer and running coincide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                r_ctx_st[i]  <= CTX_FREE;
                r_ctx_id[i]  <= '0;
                r_ctx_src[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                r_ctx_st[i]  <= CTX_FREE;
                r_ctx_id[i]  <= '0;
                r_ctx_src[i] <= '0;
            end
        end else begin
            if (w_acq_fire) begin
                r_ctx_st[r_ptr] <= CTX_ACQUIRED;
                r_ctx_id[r_ptr] <= r_job_id;
            end
            if (w_trg_fire) begin
                r_ctx_st[r_ptr]  <= CTX_READY;
                r_ctx_src[r_ptr] <= trigger_src_i;
            end
            if (w_end) begin
                r_ctx_st[r_run] <= CTX_FREE;
            end
        end
    end

    // Indices, job-ID counter, free count and error pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_run     <= '0;
            r_job_id  <= '0;
            r_nb_free <= FW'(N_CONTEXT);
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_ptr     <= '0;
            r_run     <= '0;
            r_job_id  <= '0;
            r_nb_free <= FW'(N_CONTEXT);
            r_err     <= 1'b0;
        end else begin
            if (w_trg_fire) r_ptr <= r_ptr + CW'(1);
            if (w_end)      r_run <= r_run + CW'(1);
            if (w_acq_fire) r_job_id <= r_job_id + ID_WIDTH'(1);
            r_nb_free <= r_nb_free - FW'(w_acq_fire) + FW'(w_end);
            r_err     <= w_acq_err | w_trg_err | w_done_err;
        end
    end

    // Job-done event on line 0 of the core that triggered the job
    always_comb begin
        w_evt = '0;
        for (int c = 0; c < N_CORES; c++) begin
            w_evt[c*N_EVT] = w_end && (r_ctx_src[r_run] == SW'(c));
        end
    end

    assign acquire_ok_o      = w_acq_ok;
    assign job_id_o          = r_job_id;
    assign pointer_context_o = r_ptr;
    assign running_context_o = r_run;
    assign running_job_id_o  = r_ctx_id[r_run];
    assign start_o           = (r_state == SCHED_START);
    assign busy_o            = (r_state == SCHED_START) ||
                               (r_state == SCHED_RUN);
    assign nb_free_o         = r_nb_free;
    assign evt_o             = w_evt;
    assign err_o             = r_err;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Self-checking bench for hwpe_ctrl_ctx_sched: directed table,
// hand-written corner sequences and randomized traffic vs a model.
module tb_hwpe_ctrl_ctx_sched;

    localparam int NC = 2;
    localparam int NCORE = 16;
    localparam int NEVT = 2;

    // model encodings
    localparam int M_FREE = 0, M_ACQ = 1, M_RDY = 2;
    localparam int E_IDLE = 0, E_START = 1, E_RUN = 2, E_END = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        acq;
    logic        trg;
    logic [3:0]  src;
    logic        done;
    logic        ok;
    logic [7:0]  jid;
    logic        ptr;
    logic        run;
    logic [7:0]  rjid;
    logic        start;
    logic        busy;
    logic [1:0]  nb;
    logic [31:0] evt;
    logic        err;

    always #5 clk = ~clk;

    hwpe_ctrl_ctx_sched #(
        .N_CONTEXT(NC), .N_CORES(NCORE), .N_EVT(NEVT), .ID_WIDTH(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .acquire_i(acq), .acquire_ok_o(ok), .job_id_o(jid),
        .trigger_i(trg), .trigger_src_i(src),
        .pointer_context_o(ptr), .running_context_o(run),
        .running_job_id_o(rjid), .start_o(start), .done_i(done),
        .busy_o(busy), .nb_free_o(nb), .evt_o(evt), .err_o(err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    int m_st[NC];
    int m_id[NC];
    int m_src[NC];
    int m_ptr, m_run, m_jid, m_eng;
    bit m_err;

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin
            m_st[i] = M_FREE; m_id[i] = 0; m_src[i] = 0;
        end
        m_ptr = 0; m_run = 0; m_jid = 0; m_eng = E_IDLE; m_err = 0;
    endfunction

    function automatic int m_nfree();
        int n = 0;
        foreach (m_st[i]) if (m_st[i] == M_FREE) n++;
        return n;
    endfunction

    function automatic longint m_evt();
        if (m_eng == E_END) return longint'(1) << (m_src[m_run] * NEVT);
        return 0;
    endfunction

    function automatic void m_step(bit a, bit t, int s, bit d, bit c);
        int old[NC];
        int ps;
        bit e;
        if (c) begin
            m_reset();
            return;
        end
        old = m_st;
        ps = old[m_ptr];
        e = 0;
        if (a) begin
            if (ps == M_FREE) begin
                m_st[m_ptr] = M_ACQ;
                m_id[m_ptr] = m_jid;
                m_jid = (m_jid + 1) % 256;
            end else if (ps == M_ACQ) e = 1;
        end
        if (t) begin
            if (ps == M_ACQ) begin
                m_st[m_ptr] = M_RDY;
                m_src[m_ptr] = s;
                m_ptr = (m_ptr + 1) % NC;
            end else e = 1;
        end
        if (d && m_eng != E_RUN) e = 1;
        case (m_eng)
            E_IDLE:  if (old[m_run] == M_RDY) m_eng = E_START;
            E_START: m_eng = E_RUN;
            E_RUN:   if (d) m_eng = E_END;
            default: begin
                m_st[m_run] = M_FREE;
                m_run = (m_run + 1) % NC;
                m_eng = E_IDLE;
            end
        endcase
        m_err = e;
    endfunction

    task automatic m_check();
        chk("acquire_ok", ok, m_st[m_ptr] == M_FREE);
        chk("job_id", jid, m_jid);
        chk("pointer", ptr, m_ptr);
        chk("running", run, m_run);
        chk("running_job_id", rjid, m_id[m_run]);
        chk("start", start, m_eng == E_START);
        chk("busy", busy, m_eng == E_START || m_eng == E_RUN);
        chk("nb_free", nb, m_nfree());
        chk("evt", evt, m_evt());
        chk("err", err, m_err);
    endtask

    // ---------------- stimulus helpers ----------------
    logic        s_ok, s_start, s_busy, s_err, s_ptr, s_run;
    logic [7:0]  s_jid, s_rjid;
    logic [1:0]  s_nb;
    logic [31:0] s_evt;

    // One clock cycle: drive, sample + check at negedge, advance model.
    task automatic step(input bit a, input bit t, input int s, input bit d);
        acq = a; trg = t; src = 4'(s); done = d;
        @(negedge clk);
        s_ok = ok; s_start = start; s_busy = busy; s_err = err;
        s_ptr = ptr; s_run = run; s_jid = jid; s_rjid = rjid;
        s_nb = nb; s_evt = evt;
        m_check();
        @(posedge clk);
        m_step(a, t, s, d, clear);
        #1;
        acq = 0; trg = 0; done = 0; clear = 0;
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic do_reset();
        #2;
        rst = 1;
        m_reset();
        @(negedge clk);
        m_check();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        bit a; bit t; int s; bit d;
        bit st; bit bz; bit ok; bit er;
        int nb; int ev; int jid; int ptr; int run;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1; clear = 0; acq = 0; trg = 0; src = 0; done = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // a  t  s  d | st bz ok er nb ev jid ptr run
        tbl[0]  = '{0,0,0,0, 0,0,1,0, 2,-1,0,0,0};
        tbl[1]  = '{1,0,0,0, 0,0,1,0, 2,-1,0,0,0};
        tbl[2]  = '{0,1,3,0, 0,0,0,0, 1,-1,1,0,0};
        tbl[3]  = '{0,0,0,0, 0,0,1,0, 1,-1,1,1,0};
        tbl[4]  = '{0,0,0,0, 1,1,1,0, 1,-1,1,1,0};
        tbl[5]  = '{0,0,0,0, 0,1,1,0, 1,-1,1,1,0};
        tbl[6]  = '{0,0,0,0, 0,1,1,0, 1,-1,1,1,0};
        tbl[7]  = '{0,0,0,0, 0,1,1,0, 1,-1,1,1,0};
        tbl[8]  = '{0,0,0,0, 0,1,1,0, 1,-1,1,1,0};
        tbl[9]  = '{0,0,0,1, 0,1,1,0, 1,-1,1,1,0};
        tbl[10] = '{0,0,0,0, 0,0,1,0, 1, 3,1,1,0};
        tbl[11] = '{0,0,0,0, 0,0,1,0, 2,-1,1,1,1};
        tbl[12] = '{0,1,5,0, 0,0,1,0, 2,-1,1,1,1};
        tbl[13] = '{0,0,0,1, 0,0,1,1, 2,-1,1,1,1};
        tbl[14] = '{0,0,0,0, 0,0,1,1, 2,-1,1,1,1};
        tbl[15] = '{0,0,0,0, 0,0,1,0, 2,-1,1,1,1};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].a, tbl[i].t, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl%0d_start", i), s_start, tbl[i].st);
            chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].bz);
            chk($sformatf("tbl%0d_ok", i), s_ok, tbl[i].ok);
            chk($sformatf("tbl%0d_err", i), s_err, tbl[i].er);
            chk($sformatf("tbl%0d_nb", i), s_nb, tbl[i].nb);
            chk($sformatf("tbl%0d_evt", i), s_evt,
                tbl[i].ev < 0 ? 0 : longint'(1) << (tbl[i].ev * NEVT));
            chk($sformatf("tbl%0d_jid", i), s_jid, tbl[i].jid);
            chk($sformatf("tbl%0d_ptr", i), s_ptr, tbl[i].ptr);
            chk($sformatf("tbl%0d_run", i), s_run, tbl[i].run);
        end

        // Two jobs back-to-back, full condition, restart latency.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 2, 0);
        step(1, 0, 0, 0);
        chk("full_ok", s_ok, 0);
        step(0, 0, 0, 0);
        chk("full_jid", s_jid, 2);
        chk("full_err", s_err, 0);
        chk("full_nb", s_nb, 0);
        chk("q_run0", s_run, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("q_evt1", s_evt, 32'h1 << 2);
        step(0, 0, 0, 0);
        chk("q_nostart", s_start, 0);
        step(0, 0, 0, 0);
        chk("q_start2", s_start, 1);
        chk("q_run1", s_run, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("q_evt2", s_evt, 32'h1 << 4);
        step(0, 0, 0, 0);
        chk("q_run_back", s_run, 0);
        chk("q_nb2", s_nb, 2);

        // Job-ID wrap and trigger coinciding with END.
        do_reset();
        for (int j = 0; j < 255; j++) begin
            step(1, 0, 0, 0);
            step(0, 1, j % 16, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        chk("wrap_pre", s_jid, 255);
        step(0, 1, 7, 0);
        chk("wrap_jid", s_jid, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_rjid", s_rjid, 255);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 9, 0);
        chk("coinc_evt", s_evt, 32'h1 << 14);
        step(0, 0, 0, 0);
        chk("coinc_nb", s_nb, 1);
        chk("coinc_ptr", s_ptr, 1);
        chk("coinc_run", s_run, 0);
        chk("coinc_err", s_err, 0);
        step(0, 0, 0, 0);
        chk("coinc_start", s_start, 1);
        chk("coinc_rjid", s_rjid, 0);

        // Reset mid-RUN, then a late done.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 4, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_prerun", s_busy, 1);
        do_reset();
        step(0, 0, 0, 1);
        chk("rst_evt", s_evt, 0);
        step(0, 0, 0, 0);
        chk("rst_err", s_err, 1);
        chk("rst_nb", s_nb, 2);
        chk("rst_ok", s_ok, 1);
        chk("rst_busy", s_busy, 0);

        // Same with synchronous clear.
        step(1, 0, 0, 0);
        step(0, 1, 6, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        clear = 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("clr_evt", s_evt, 0);
        chk("clr_busy", s_busy, 0);
        step(0, 0, 0, 0);
        chk("clr_err", s_err, 1);
        chk("clr_nb", s_nb, 2);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            clear = ($urandom_range(0, 99) < 2);
            step($urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 35,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 25);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
